silife_sequencer: RTL

SILIFE_SEQUENCER -- requirements
Module: silife_sequencer

---
 rtl/silife_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/silife_sequencer.sv
// silife_sequencer -- command sequencer for an 8x8 Life cell grid.
//
// Accepts LOAD / RUN / READ / CLEAR commands and drives the grid-side write,
// step and row-select controls.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake; cmd_op selects the operation,
//                       cmd_arg is the RUN generation count
//   in_valid/ready    : LOAD row stream (in_data, rows 0..7 in order)
//   out_valid/ready   : READ row stream (out_data, out_last on row 7)
//   abort             : synchronous cancel of the active command
//   done              : one-cycle completion pulse
//   gen_count         : generations stepped since the last LOAD/CLEAR
//   grid_*            : row select, set/clear masks, step enable, row readback
module silife_sequencer #(
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GEN_W-1:0] cmd_arg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             abort,
  output logic             done,
  output logic [15:0]      gen_count,
  output logic [2:0]       grid_row_select,
  output logic [7:0]       grid_set_cells,
  output logic [7:0]       grid_clear_cells,
  output logic             grid_enable,
  input  logic [7:0]       grid_cells
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ,
    S_CLEAR
  } state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [GEN_W-1:0] cnt, cnt_n;
  logic [15:0]      gen_n;
  logic             done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      gen_count <= '0;
      done      <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gen_count <= gen_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n          = state;
    ptr_n            = ptr;
    cnt_n            = cnt;
    gen_n            = gen_count;
    done_n           = 1'b0;
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_last         = 1'b0;
    grid_row_select  = '0;
    grid_set_cells   = '0;
    grid_clear_cells = '0;
    grid_enable      = 1'b0;

    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_n = '0;
          cnt_n = cmd_arg;
          unique case (cmd_op)
            2'b00: state_n = S_LOAD;
            2'b01: state_n = S_RUN;
            2'b10: state_n = S_READ;
            2'b11: state_n = S_CLEAR;
          endcase
        end
      end
      S_LOAD: begin
        in_ready        = 1'b1;
        grid_row_select = ptr;
        if (in_valid) begin
          grid_set_cells   = in_data;
          grid_clear_cells = ~in_data;
          ptr_n            = ptr + 3'd1;
          if (ptr == 3'd7) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      S_RUN: begin
        // cnt holds the remaining steps; an arg of 0 spends one idle cycle here.
        if (cnt != '0) begin
          grid_enable = 1'b1;
          cnt_n       = cnt - GEN_W'(1);
          gen_n       = gen_count + 16'd1;
          if (cnt == GEN_W'(1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_READ: begin
        out_valid       = 1'b1;
        grid_row_select = ptr;
        out_data        = grid_cells;
        out_last        = (ptr == 3'd7);
        if (out_ready) begin
          ptr_n = ptr + 3'd1;
          if (ptr == 3'd7) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        grid_row_select  = ptr;
        grid_clear_cells = 8'hFF;
        ptr_n            = ptr + 3'd1;
        if (ptr == 3'd7) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort keeps this cycle's beat/step but cancels completion; the
    // gen_count reset below is tied to an actual (non-aborted) completion.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      done_n  = 1'b0;
    end
    if (done_n && (state == S_LOAD || state == S_CLEAR)) gen_n = '0;
  end

endmodule
